// File: rtl/pipeline_sequencer.sv
// Steps one instruction IF->ID->EX->MM->WB with one-hot stage enables; traps to FAULT on memory ack timeout.
// Latency: 5 cycles per zero-wait instruction, +1 per ack wait cycle; all outputs Moore from registered state.
// Backpressure: IF/MM hold their request until ack; SEQ_RETIRE_CNT_EN enables the retired-instruction counter.
module pipeline_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             mem_op,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic [4:0]       stage_en,
    output logic [2:0]       state,
    output logic             fault,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] retired
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EX    = 3'b010,
        S_MM    = 3'b011,
        S_WB    = 3'b100,
        S_IDLE  = 3'b101,
        S_FAULT = 3'b110,
        S_ILL   = 3'b111
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              w_wait_inc;
    logic              r_mem_op_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_mem_op_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_wait_inc)
                r_wait <= r_wait + WAIT_W'(1);
            if (r_state == S_EX)
                r_mem_op_q <= mem_op;
        end
    end

    // An ack arriving on the limit cycle takes priority over the timeout trap.
    always_comb begin
        w_next     = r_state;
        w_wait_inc = 1'b0;
        case (r_state)
            S_IDLE:  if (run) w_next = S_IF;
            S_IF: begin
                if (imem_ack)               w_next = S_ID;
                else if (r_wait == WAIT_LIM) w_next = S_FAULT;
                else                        w_wait_inc = 1'b1;
            end
            S_ID:    w_next = S_EX;
            S_EX:    w_next = S_MM;
            S_MM: begin
                if (!r_mem_op_q || dmem_ack) w_next = S_WB;
                else if (r_wait == WAIT_LIM) w_next = S_FAULT;
                else                         w_wait_inc = 1'b1;
            end
            S_WB:    w_next = run ? S_IF : S_IDLE;
            S_FAULT: if (fault_clr) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stage_en = 5'b00000;
        case (r_state)
            S_IF:    stage_en = 5'b00001;
            S_ID:    stage_en = 5'b00010;
            S_EX:    stage_en = 5'b00100;
            S_MM:    stage_en = 5'b01000;
            S_WB:    stage_en = 5'b10000;
            default: stage_en = 5'b00000;
        endcase
    end

    assign state    = r_state;
    assign imem_req = (r_state == S_IF);
    assign dmem_req = (r_state == S_MM) && r_mem_op_q;
    assign fault    = (r_state == S_FAULT);

`ifdef SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retired <= '0;
        else if (r_state == S_WB)
            r_retired <= r_retired + CNT_W'(1);
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif
endmodule
